mole_button_conditioner: RTL and testbench
==========================================

MOLE_BUTTON_CONDITIONER -- requirements
Module: mole_button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 5000, consecutive synchronized-stable cycles needed to accept a level change (5 ms at 1 MHz); legal range 2..65535.
REQ-002 Parameter NUM_BTN, default 8, number of button channels (one per game mole input).
REQ-003 clk  input  1  system clock, 1 MHz nominal; one clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 btn_raw  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
REQ-006 en  input  1  synchronous enable; 0 suppresses press/release pulses and count updates.
REQ-007 cnt_clr  input  1  synchronous clear of press_count.
REQ-008 btn_level  output  NUM_BTN  debounced level per channel.
REQ-009 btn_press  output  NUM_BTN  one-cycle pulse per accepted press; this is the game's button input.
REQ-010 btn_release  output  NUM_BTN  one-cycle pulse per accepted release.
REQ-011 any_press  output  1  OR of btn_press, same cycle.
REQ-012 press_count  output  8  total accepted presses, all channels.

Function
REQ-013 Each btn_raw bit SHALL pass a 2-flop synchronizer; sync[i] is the second flop; no logic on the first flop.
REQ-014 Each channel SHALL run an independent FSM: IDLE (level 0), CONF_HI, HIGH (level 1), CONF_LO.
REQ-015 IDLE: sync=1 -> CONF_HI, counter=1; else stay.
REQ-016 CONF_HI: sync=0 -> IDLE, counter cleared, no pulse; sync=1 with counter=DEBOUNCE_CYCLES -> HIGH; else counter+1.
REQ-017 HIGH: sync=0 -> CONF_LO, counter=1; else stay.
REQ-018 CONF_LO: sync=1 -> HIGH, counter cleared, no pulse; sync=0 with counter=DEBOUNCE_CYCLES -> IDLE; else counter+1.
REQ-019 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1) bits; it never wraps.
REQ-020 On the edge entering HIGH: btn_level[i]=1 and btn_press[i]=1 (if en=1) for exactly one cycle.
REQ-021 On the edge entering IDLE from CONF_LO: btn_level[i]=0 and btn_release[i]=1 (if en=1) for exactly one cycle.
REQ-022 Latency: with edge 0 the first edge sampling new raw level and raw stable thereafter, btn_level and pulse change after edge DEBOUNCE_CYCLES+1.
REQ-023 All outputs SHALL be registered; no combinational path from btn_raw to any output.
REQ-024 en=0: FSMs and btn_level keep tracking; pulses forced 0; a transition during en=0 is lost, not deferred.
REQ-025 Simultaneous accepted presses on k channels in one cycle: all k pulses asserted; press_count += k.
REQ-026 press_count wraps modulo 256 (255 + 1 -> 0).
REQ-027 cnt_clr=1 sets press_count=0 on next edge, taking priority over same-cycle increments.

Reset
REQ-028 rst=1 SHALL immediately clear synchronizers, counters, press_count and all outputs to 0, and all FSMs to IDLE, without waiting for clk.
REQ-029 After rst deasserts, a button held through reset is a new press: btn_press after DEBOUNCE_CYCLES+2 edges, no btn_release generated.
REQ-030 Reset asserted mid-debounce SHALL abort it with no pulse, including a pending release.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 btn_raw[0] 0->1 before edge 0, held -> btn_press[0]=1 and btn_level[0]=1 after edge 5 only; press_count=1.
REQ-032 btn_raw[2] high for 3 cycles then low -> no pulse; btn_level[2] stays 0; press_count unchanged.
REQ-033 btn_raw=8'hFF together, held -> all 8 btn_press bits and any_press high in one cycle; press_count=8.
REQ-034 Held button, release with 2-cycle bounce back high, then low steady -> single btn_release 6 edges after final fall; btn_level falls same edge.
REQ-035 press_count=255, one press with cnt_clr=0 -> 0; separate press coincident with cnt_clr=1 -> 0.
REQ-036 rst pulsed mid-CONF_HI with button held -> outputs 0 immediately; after release of rst, btn_press after 6 edges, no btn_release.

Source files
------------

// File: rtl/mole_button_conditioner.sv
// mole_button_conditioner: synchronizes and debounces NUM_BTN raw buttons into level, press/release pulses and a press count.
module mole_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int NUM_BTN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               en,
  input  logic               cnt_clr,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press,
  output logic [7:0]         press_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, CONF_HI, HIGH, CONF_LO} state_t;
  logic [NUM_BTN-1:0] meta, sync, rise, fall;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    state_t st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic lvl, up, dn;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st  <= IDLE;
        cnt <= '0;
        lvl <= 1'b0;
      end else begin
        st  <= st_nx;
        cnt <= cnt_nx;
        lvl <= up ? 1'b1 : dn ? 1'b0 : lvl;
      end
    // The level flips on the edge that takes the DEBOUNCE_CYCLES-th consecutive stable sample.
    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      up     = 1'b0;
      dn     = 1'b0;
      case (st)
        IDLE: if (sync[i]) begin
          st_nx  = CONF_HI;
          cnt_nx = CW'(1);
        end
        CONF_HI: if (!sync[i]) begin
          st_nx  = IDLE;
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          st_nx  = HIGH;
          cnt_nx = '0;
          up     = 1'b1;
        end else cnt_nx = cnt + CW'(1);
        HIGH: if (!sync[i]) begin
          st_nx  = CONF_LO;
          cnt_nx = CW'(1);
        end
        CONF_LO: if (sync[i]) begin
          st_nx  = HIGH;
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          st_nx  = IDLE;
          cnt_nx = '0;
          dn     = 1'b1;
        end else cnt_nx = cnt + CW'(1);
      endcase
    end
    assign rise[i]      = up;
    assign fall[i]      = dn;
    assign btn_level[i] = lvl;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_press   <= '0;
      btn_release <= '0;
      any_press   <= 1'b0;
      press_count <= '0;
    end else begin
      btn_press   <= en ? rise : '0;
      btn_release <= en ? fall : '0;
      any_press   <= en & |rise;
      press_count <= cnt_clr ? 8'd0 : en ? press_count + 8'($countones(rise)) : press_count;
    end
endmodule

// File: tb/tb_mole_button_conditioner.sv
// tb_mole_button_conditioner: directed stimulus with a pulse scoreboard, DEBOUNCE_CYCLES=4.
module tb_mole_button_conditioner;
  logic clk = 0, rst = 1, en = 1, cnt_clr = 0;
  logic [7:0] btn_raw = '0, btn_level, btn_press, btn_release, press_count;
  logic any_press;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] mcnt = '0;
  typedef struct {int cyc; logic [7:0] press, rel, lvl; logic any; logic [7:0] cnt;} exp_t;
  exp_t q[$];
  exp_t e;

  mole_button_conditioner #(.DEBOUNCE_CYCLES(4), .NUM_BTN(8)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .en(en), .cnt_clr(cnt_clr),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .any_press(any_press), .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (!rst && (btn_press != 0 || btn_release != 0)) begin
      if (q.size() == 0) chk("unexpected_pulse", {btn_press, btn_release}, 32'h0);
      else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("btn_press", btn_press, e.press);
        chk("btn_release", btn_release, e.rel);
        chk("btn_level", btn_level, e.lvl);
        chk("any_press", any_press, e.any);
        chk("press_count", press_count, e.cnt);
      end
    end

  task automatic step(input logic [7:0] nr);
    logic [7:0] old, p, r;
    @(negedge clk);
    old = btn_raw;
    p = nr & ~old;
    r = ~nr & old;
    btn_raw = nr;
    mcnt = mcnt + 8'($countones(p));
    if ((p | r) != 0) q.push_back('{cyc + 6, p, r, nr, |p, mcnt});
    repeat (5) @(negedge clk);
    chk("lvl_hold", btn_level, old);
    @(negedge clk);
    chk("lvl_new", btn_level, nr);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_count", press_count, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    step(8'h01);
    @(negedge clk);
    btn_raw = 8'h05;
    repeat (3) @(negedge clk);
    btn_raw = 8'h01;
    repeat (10) @(negedge clk);
    chk("glitch_level", btn_level, 8'h01);
    chk("glitch_count", press_count, mcnt);
    btn_raw = 8'h00;
    @(negedge clk);
    btn_raw = 8'h01;
    repeat (2) @(negedge clk);
    chk("bounce_level", btn_level, 8'h01);
    step(8'h00);
    step(8'hFF);
    step(8'h00);
    @(negedge clk);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    mcnt = 0;
    chk("clr_count", press_count, 0);
    for (int k = 0; k < 31; k++) begin
      step(8'hFF);
      step(8'h00);
    end
    step(8'h7F);
    step(8'h00);
    chk("count_255", press_count, 8'd255);
    step(8'h01);
    step(8'h00);
    step(8'h04);
    step(8'h00);
    @(negedge clk);
    btn_raw = 8'h02;
    q.push_back('{cyc + 6, 8'h02, 8'h00, 8'h02, 1'b1, 8'h00});
    repeat (5) @(negedge clk);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    mcnt = 0;
    step(8'h00);
    @(negedge clk);
    en = 0;
    btn_raw = 8'h08;
    repeat (8) @(negedge clk);
    chk("en0_level", btn_level, 8'h08);
    chk("en0_count", press_count, mcnt);
    en = 1;
    step(8'h00);
    step(8'h20);
    @(negedge clk);
    btn_raw = 8'h30;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("arst_level", btn_level, 0);
    chk("arst_press", btn_press, 0);
    chk("arst_any", any_press, 0);
    chk("arst_count", press_count, 0);
    @(negedge clk);
    rst = 0;
    mcnt = 8'd2;
    q.push_back('{cyc + 6, 8'h30, 8'h00, 8'h30, 1'b1, 8'd2});
    repeat (15) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
